// File: rtl/width_12to8.sv
// Repacks a stream of 12-bit words into 8-bit bytes, MSB-first (2 words -> 3 bytes).
// Valid/ready on both sides; outputs are driven purely from the internal registers.
module width_12to8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  output logic        ready_in,
  input  logic [11:0] data_in,
  output logic        valid_out,
  input  logic        ready_out,
  output logic [7:0]  data_out
);

  logic [23:0] data_buf;
  logic [23:0] buf_popped;
  logic [23:0] buf_next;
  logic [4:0]  cnt;
  logic [4:0]  cnt_popped;
  logic [4:0]  cnt_next;
  logic        push;
  logic        pop;

  // Oldest bit sits at data_buf[23]; bits below the top cnt bits are kept at zero.
  assign valid_out = (cnt >= 5'd8);
  assign data_out  = data_buf[23:16];
  assign ready_in  = (cnt <= 5'd12);

  assign pop  = valid_out & ready_out;
  assign push = valid_in & ready_in;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    buf_popped = data_buf;
    cnt_popped = cnt;
    if (pop) begin
      buf_popped = {data_buf[15:0], 8'h00};
      cnt_popped = cnt - 5'd8;
    end

    buf_next = buf_popped;
    cnt_next = cnt_popped;
    if (push) begin
      // The free bits below the valid region are zero, so OR-ing the aligned word places it.
      buf_next = buf_popped | ({data_in, 12'h000} >> cnt_popped);
      cnt_next = cnt_popped + 5'd12;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all registered state.
    if (!rst_n) begin
      data_buf <= 24'h000000;
      cnt      <= 5'd0;
    end else begin
      data_buf <= buf_next;
      cnt      <= cnt_next;
    end
  end

endmodule

// File: tb/tb_width_12to8.sv
// Directed and random checks for the 12-to-8 repacker; inputs change 1 ns after the
// rising edge and outputs are sampled on the falling edge.
module tb_width_12to8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [11:0] data_in;
  logic        valid_out;
  logic        ready_out;
  logic [7:0]  data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0]  got_q [$];
  logic [11:0] words [2000];

  width_12to8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .data_in   (data_in),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  // Byte capture: a pop occurs at the next rising edge whenever both are high here.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) got_q.push_back(data_out);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    data_in   = 12'h000;
    tick();
    tick();
    rst_n = 1'b1;
    got_q.delete();
  endtask

  // Offers one word and holds it until accepted (bounded).
  task automatic push_word(input logic [11:0] w);
    bit done = 0;
    valid_in = 1'b1;
    data_in  = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ready_in) done = 1;
      tick();
    end
    valid_in = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: word %h not accepted within 50 cycles", w);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    valid_in  = 1'b1;
    data_in   = 12'hFFF;
    ready_out = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready_in: got %b expected 1", ready_in); end
    checks++;
    if (dut.cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt); end
    tick();
    rst_n    = 1'b1;
    valid_in = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (dut.cnt !== 5'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: cnt %0d valid_out %b expected 0 and 0", dut.cnt, valid_out);
    end
  endtask

  task automatic test_basic_pack();
    logic [7:0] exp_q [$] = '{8'hAB, 8'hCD, 8'hEF};
    do_reset();
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = 12'hABC;
    @(negedge clk);
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL basic_ready_in0: got %b expected 1", ready_in); end
    tick();
    data_in = 12'hDEF;
    @(negedge clk);
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL basic_ready_in1: got %b expected 1", ready_in); end
    tick();
    valid_in = 1'b0;
    repeat (5) tick();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL basic_count: got %0d bytes expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL basic_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_residual_hold();
    logic [7:0] exp_q [$] = '{8'h12, 8'h34, 8'h56};
    do_reset();
    ready_out = 1'b1;
    push_word(12'h123);
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || dut.cnt !== 5'd4) begin
        errors++;
        $display("FAIL residual_hold[%0d]: valid_out %b cnt %0d expected 0 and 4", i, valid_out, dut.cnt);
      end
      tick();
    end
    push_word(12'h456);
    repeat (5) tick();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL residual_count: got %0d bytes expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL residual_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_q [$] = '{8'h11, 8'h12, 8'h22, 8'h33};
    do_reset();
    ready_out = 1'b0;
    push_word(12'h111);
    push_word(12'h222);
    valid_in = 1'b1;
    data_in  = 12'h333;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ready_in !== 1'b0 || dut.cnt !== 5'd24 || valid_out !== 1'b1 || data_out !== 8'h11) begin
        errors++;
        $display("FAIL bp_full[%0d]: ready_in %b cnt %0d valid_out %b data_out %h expected 0 24 1 11",
                 i, ready_in, dut.cnt, valid_out, data_out);
      end
      tick();
    end
    ready_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bit acc;
      @(negedge clk);
      acc = valid_in && ready_in;
      tick();
      if (acc) valid_in = 1'b0;
    end
    checks++;
    if (valid_in !== 1'b0) begin errors++; $display("FAIL bp_333_accept: valid_in still %b expected 0", valid_in); end
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.cnt !== 5'd4 || valid_out !== 1'b0 || dut.data_buf[23:20] !== 4'h3) begin
      errors++;
      $display("FAIL bp_residual: cnt %0d valid_out %b nibble %h expected 4 0 3",
               dut.cnt, valid_out, dut.data_buf[23:20]);
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d bytes expected 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [7:0] exp_q [$] = '{8'hAB, 8'hCD, 8'hEF};
    do_reset();
    ready_out = 1'b0;
    push_word(12'hABC);
    @(negedge clk);
    checks++;
    if (dut.cnt !== 5'd12 || valid_out !== 1'b1 || data_out !== 8'hAB) begin
      errors++;
      $display("FAIL pp_pre: cnt %0d valid_out %b data_out %h expected 12 1 AB", dut.cnt, valid_out, data_out);
    end
    tick();
    ready_out = 1'b1;
    valid_in  = 1'b1;
    data_in   = 12'hDEF;
    @(negedge clk);
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL pp_ready_in: got %b expected 1", ready_in); end
    tick();
    valid_in = 1'b0;
    @(negedge clk);
    checks++;
    if (dut.cnt !== 5'd16) begin errors++; $display("FAIL pp_cnt: got %0d expected 16", dut.cnt); end
    repeat (5) tick();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL pp_count: got %0d bytes expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL pp_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [7:0] exp_q [$] = '{8'hAB, 8'hCD, 8'hEF};
    do_reset();
    ready_out = 1'b1;
    push_word(12'h123);
    tick();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 8'h12) begin
      errors++;
      $display("FAIL rst_mid_first: got %0d bytes, first %h expected 1 byte 12", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    rst_n    = 1'b0;
    valid_in = 1'b1;
    data_in  = 12'hFFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0 || data_out !== 8'h00 || dut.cnt !== 5'd0) begin
        errors++;
        $display("FAIL rst_mid_hold[%0d]: valid_out %b data_out %h cnt %0d expected 0 00 0",
                 i, valid_out, data_out, dut.cnt);
      end
      tick();
    end
    valid_in = 1'b0;
    rst_n    = 1'b1;
    got_q.delete();
    push_word(12'hABC);
    push_word(12'hDEF);
    repeat (5) tick();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("FAIL rst_mid_count: got %0d bytes expected 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rst_mid_byte[%0d]: got %h expected %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random_soak();
    int         idx = 0;
    int         cycles = 0;
    int         bad_bytes = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_byte = 8'h00;
    logic [7:0] exp_b [3];
    do_reset();
    for (int i = 0; i < 2000; i++) words[i] = 12'($urandom);
    valid_in  = 1'b1;
    data_in   = words[0];
    ready_out = 1'b1;
    while ((idx < 2000 || valid_out) && cycles < 20000) begin
      @(negedge clk);
      if (prev_stall) begin
        checks++;
        if (valid_out !== 1'b1 || data_out !== prev_byte) begin
          errors++;
          $display("FAIL soak_stall: valid_out %b data_out %h expected 1 %h", valid_out, data_out, prev_byte);
        end
      end
      if (valid_in && ready_in) idx++;
      prev_stall = valid_out && !ready_out;
      prev_byte  = data_out;
      tick();
      cycles++;
      valid_in  = (idx < 2000) && ($urandom_range(0, 3) != 0);
      data_in   = (idx < 2000) ? words[idx] : 12'h000;
      ready_out = (idx >= 2000) || ($urandom_range(0, 3) != 0);
    end
    valid_in  = 1'b0;
    ready_out = 1'b0;
    checks++;
    if (cycles >= 20000) begin
      errors++;
      $display("FAIL soak_timeout: %0d words accepted after %0d cycles expected 2000", idx, cycles);
    end
    checks++;
    if (got_q.size() != 3000) begin
      errors++;
      $display("FAIL soak_count: got %0d bytes expected 3000", got_q.size());
    end else begin
      for (int k = 0; k < 1000; k++) begin
        exp_b[0] = words[2*k][11:4];
        exp_b[1] = {words[2*k][3:0], words[2*k+1][11:8]};
        exp_b[2] = words[2*k+1][7:0];
        for (int j = 0; j < 3; j++) begin
          checks++;
          if (got_q[3*k+j] !== exp_b[j]) begin
            errors++;
            if (bad_bytes < 10)
              $display("FAIL soak_byte[%0d]: got %h expected %h", 3*k+j, got_q[3*k+j], exp_b[j]);
            bad_bytes++;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_residual_hold();
    test_backpressure();
    test_push_pop_same_cycle();
    test_reset_mid_stream();
    test_random_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/width_12to8.md
Name: width_12to8

Overview:
- Downstream partner of the 8-to-12 packer: takes a stream of 12-bit words and repacks it MSB-first into a stream of 8-bit bytes.
- Every 2 input words become 3 output bytes.
- Valid/ready on both sides, so it absorbs backpressure from the byte consumer and stalls the word producer.
- Sits between a 12-bit processing stage and an 8-bit sink; bit order is the exact inverse of the 8-to-12 packer.

Parameters:
- None. Widths fixed: 12 in, 8 out. Internal buffer 24 bits; fill count 5 bits.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- valid_in  input  1  data_in holds a word
- ready_in  output  1  block can accept a word this cycle
- data_in  input  12  input word, bit 11 transmitted first
- valid_out  output  1  data_out holds a byte
- ready_out  input  1  consumer accepts the byte this cycle
- data_out  output  8  output byte, bit 7 is oldest

Behaviour:
- State:
  - buf[23:0]: MSB-aligned; the oldest bit is buf[23].
  - cnt: number of valid bits, always in {0,4,...,24}.
  - Bits of buf below the top cnt bits are always 0.
- Reset (async, rst_n=0):
  - buf=0, cnt=0, so valid_out=0 and data_out=8'h00.
  - ready_in follows cnt, so it reads 1 during reset; all inputs are ignored while in reset.
- Combinational outputs (registers only, no path from the input side):
  - valid_out = (cnt >= 8).
  - data_out = buf[23:16].
  - ready_in = (cnt <= 12). ready_in does NOT depend on ready_out.
- Transfer events:
  - pop = valid_out & ready_out.
  - push = valid_in & ready_in.
- Next-state, evaluated in order:
  1. If pop: buf = buf << 8, zero-filled; cnt = cnt - 8.
  2. If push: write data_in into buf[23-cnt' -: 12], where cnt' is the count after step 1; cnt = cnt' + 12.
- Simultaneous push and pop in the same cycle is legal and is fully handled by the ordering above.
- Because cnt' <= 12 when push is allowed, the write never overflows bit 0 and cnt never exceeds 24.
- Latency: a word accepted at edge N makes its first byte visible after edge N. The byte is valid at the next edge if cnt >= 8 after the update.
- Throughput with ready_out held at 1: sustained 3 bytes per 2 words.
  - Input stalls (ready_in=0) only when cnt > 12.
  - Output idles only when cnt < 8.
- Residual handling:
  - A 4-bit residual (cnt=4) is held indefinitely until the next word arrives.
  - There is no flush; an odd trailing nibble is never emitted alone.
- Backpressure:
  - With ready_out=0 the buffer fills to cnt=24, then ready_in=0.
  - data_out and valid_out stay stable while valid_out=1 and ready_out=0.
- Protocol:
  - valid_in may drop without a transfer; the block does not require valid_in to be held.
  - valid_out, once high, stays high until the pop.
- Reset mid-operation discards all buffered bits, including any residual nibble; the first byte after reset comes only from post-reset words.

Test Plan:
- Basic pack:
  - Stimulus: ready_out=1; push 12'hABC then 12'hDEF on back-to-back cycles.
  - Required: bytes 8'hAB, 8'hCD, 8'hEF in order; ready_in never drops.
- Residual hold:
  - Stimulus: push 12'h123 only.
  - Required: 8'h12 popped; then valid_out=0 with cnt=4 for 10 cycles.
  - Then push 12'h456. Required: bytes 8'h34, 8'h56.
- Backpressure fill:
  - Stimulus: ready_out=0; offer 12'h111, 12'h222, 12'h333 continuously.
  - Required: first two accepted, then ready_in=0 with cnt=24; data_out stays 8'h11.
  - Then raise ready_out. Required: bytes 11,12,22, then 33 (0x333 accepted once ready_in rises), with 12'h333's residual nibble 3 held at the end.
- Simultaneous push/pop:
  - Stimulus: at cnt=12 (after 12'hABC, no pop yet), assert ready_out=1 and push 12'hDEF in the same cycle.
  - Required: cnt becomes 16; output sequence is AB, CD, EF.
- Reset mid-stream:
  - Stimulus: push 12'h123, pop 8'h12, assert rst_n=0 for 2 cycles, release, push 12'hABC and 12'hDEF.
  - Required: outputs 8'hAB, 8'hCD, 8'hEF with no leftover nibble 3; valid_out=0 and data_out=0 during reset.
- Random soak:
  - Stimulus: 2000 random words with random valid_in and ready_out.
  - Required: byte stream equals the scoreboard MSB-first concatenation; valid_out and data_out stay stable under stall.
